// File: rtl/ysyx_rob_mc.sv
// ysyx_rob_mc: reorder buffer with rename table, operand forwarding, in-order multi-commit and flush
// Ports:
//   clock, reset (async, active-low)
//   disp_*      : one dispatch per cycle; disp_dest returns the allocated tag (index+1)
//   rs1_*/rs2_* : combinational operand lookup (producer tag or forwarded value)
//   wb_*        : NUM_WB out-of-order writeback ports addressed by tag
//   cm_*        : up to COMMIT_W in-order retirements per cycle, contiguous from slot 0
//   flush_pipeline : registered one-cycle pulse after a mispredicted branch or fence.i commits
module ysyx_rob_mc #(
    parameter int ROB_SIZE = 8,
    parameter int COMMIT_W = 2,
    parameter int NUM_WB   = 2,
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 16,
    localparam int RL = $clog2(REG_NUM),
    localparam int IW = $clog2(ROB_SIZE),
    localparam int TW = IW + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [4:0]               disp_rd,
    input  logic [XLEN-1:0]          disp_pc,
    input  logic [XLEN-1:0]          disp_pnpc,
    input  logic                     disp_store,
    input  logic                     disp_fence_i,
    input  logic [4:0]               disp_rs1,
    input  logic [4:0]               disp_rs2,
    output logic [TW-1:0]            disp_dest,
    output logic [TW-1:0]            rs1_q,
    output logic                     rs1_fwd,
    output logic [XLEN-1:0]          rs1_value,
    output logic [TW-1:0]            rs2_q,
    output logic                     rs2_fwd,
    output logic [XLEN-1:0]          rs2_value,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TW-1:0]     wb_dest,
    input  logic [NUM_WB*XLEN-1:0]   wb_result,
    input  logic [NUM_WB*XLEN-1:0]   wb_npc,
    input  logic [NUM_WB-1:0]        wb_br,
    output logic [COMMIT_W-1:0]      cm_valid,
    output logic [COMMIT_W*5-1:0]    cm_rd,
    output logic [COMMIT_W*XLEN-1:0] cm_value,
    output logic [COMMIT_W*XLEN-1:0] cm_pc,
    output logic [COMMIT_W*XLEN-1:0] cm_npc,
    output logic [COMMIT_W-1:0]      cm_store,
    output logic                     flush_pipeline
);

    // entry state: busy=0 FREE, busy&!done EX, busy&done WB
    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_done;
    logic [ROB_SIZE-1:0] r_store;
    logic [ROB_SIZE-1:0] r_fence;
    logic [ROB_SIZE-1:0] r_br;
    logic [4:0]          r_rd    [ROB_SIZE];
    logic [XLEN-1:0]     r_pc    [ROB_SIZE];
    logic [XLEN-1:0]     r_pnpc  [ROB_SIZE];
    logic [XLEN-1:0]     r_npc   [ROB_SIZE];
    logic [XLEN-1:0]     r_value [ROB_SIZE];
    logic [IW-1:0]       r_head;
    logic [IW-1:0]       r_tail;
    logic [IW:0]         r_count;
    logic [REG_NUM-1:0]  r_rf_busy;
    logic [IW-1:0]       r_rf_reorder [REG_NUM];
    logic                r_flush;

    logic                w_disp;
    logic [RL-1:0]       w_drd;
    logic                w_wb_hit [NUM_WB];
    logic [IW-1:0]       w_wb_idx [NUM_WB];
    logic [IW-1:0]       w_cidx   [COMMIT_W];
    logic                w_cstop  [COMMIT_W];
    logic [RL-1:0]       w_crd    [COMMIT_W];
    logic                w_crel   [COMMIT_W];
    logic [IW:0]         w_ncm;
    logic                w_stop_cm;
    logic [4:0]          w_rs     [2];
    logic [TW-1:0]       w_q      [2];
    logic                w_fwd    [2];
    logic [XLEN-1:0]     w_val    [2];

    assign flush_pipeline = r_flush;
    assign disp_ready     = (r_count < (IW+1)'(ROB_SIZE)) && !r_flush;
    assign w_disp         = disp_valid && disp_ready;
    assign disp_dest      = {1'b0, r_tail} + TW'(1);
    assign w_drd          = disp_rd[RL-1:0];

    // writeback decode: only tags that name an entry currently in EX take effect
    always_comb begin
        for (int i = 0; i < NUM_WB; i++) begin
            w_wb_idx[i] = IW'(wb_dest[i*TW +: TW] - TW'(1));
            w_wb_hit[i] = wb_valid[i] && !r_flush && (wb_dest[i*TW +: TW] != '0) &&
                          (wb_dest[i*TW +: TW] <= TW'(ROB_SIZE)) &&
                          r_busy[w_wb_idx[i]] && !r_done[w_wb_idx[i]];
        end
    end

    // commit selection: a run of WB entries from head, cut after the first stop entry
    always_comb begin : commit_sel
        logic ok;
        ok        = !r_flush;
        w_ncm     = '0;
        w_stop_cm = 1'b0;
        cm_valid  = '0;
        cm_rd     = '0;
        cm_value  = '0;
        cm_pc     = '0;
        cm_npc    = '0;
        cm_store  = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            w_cidx[k]  = r_head + IW'(k);
            w_cstop[k] = r_fence[w_cidx[k]] || (r_br[w_cidx[k]] && (r_npc[w_cidx[k]] != r_pnpc[w_cidx[k]]));
            ok         = ok && r_done[w_cidx[k]];
            cm_valid[k] = ok;
            ok         = ok && !w_cstop[k];
            cm_rd[k*5 +: 5]       = r_rd[w_cidx[k]];
            cm_value[k*XLEN +: XLEN] = r_value[w_cidx[k]];
            cm_pc[k*XLEN +: XLEN]    = r_pc[w_cidx[k]];
            cm_npc[k*XLEN +: XLEN]   = r_npc[w_cidx[k]];
            cm_store[k] = r_store[w_cidx[k]];
            // only the entry the rename table still points at may release the register;
            // a younger same-rd slot cannot match, so the youngest slot decides
            w_crd[k]  = r_rd[w_cidx[k]][RL-1:0];
            w_crel[k] = (r_rd[w_cidx[k]] != 5'd0) && (r_rf_reorder[w_crd[k]] == w_cidx[k]);
            w_ncm     = w_ncm + (IW+1)'(cm_valid[k]);
            w_stop_cm = w_stop_cm || (cm_valid[k] && w_cstop[k]);
        end
    end

    // operand lookup: ROB value first, then same-cycle writeback bypass (lowest port wins)
    assign w_rs[0] = disp_rs1;
    assign w_rs[1] = disp_rs2;
    always_comb begin : lookup
        logic [RL-1:0] r;
        logic [IW-1:0] p;
        for (int n = 0; n < 2; n++) begin
            r        = w_rs[n][RL-1:0];
            p        = r_rf_reorder[r];
            w_q[n]   = '0;
            w_fwd[n] = 1'b0;
            w_val[n] = '0;
            if (w_rs[n] != 5'd0 && r_rf_busy[r]) begin
                if (r_done[p]) begin
                    w_fwd[n] = 1'b1;
                    w_val[n] = r_value[p];
                end else begin
                    w_q[n] = {1'b0, p} + TW'(1);
                    for (int i = NUM_WB - 1; i >= 0; i--) begin
                        if (w_wb_hit[i] && w_wb_idx[i] == p) begin
                            w_q[n]   = '0;
                            w_fwd[n] = 1'b1;
                            w_val[n] = wb_result[i*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    assign rs1_q     = w_q[0];
    assign rs1_fwd   = w_fwd[0];
    assign rs1_value = w_val[0];
    assign rs2_q     = w_q[1];
    assign rs2_fwd   = w_fwd[1];
    assign rs2_value = w_val[1];

    // control state; the flush cycle itself does nothing but empty the buffer at its end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy    <= '0;
            r_done    <= '0;
            r_rf_busy <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_flush   <= 1'b0;
        end else if (r_flush) begin
            r_busy    <= '0;
            r_done    <= '0;
            r_rf_busy <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_flush   <= 1'b0;
        end else begin
            r_flush <= w_stop_cm;
            for (int i = 0; i < NUM_WB; i++)
                if (w_wb_hit[i]) r_done[w_wb_idx[i]] <= 1'b1;
            for (int k = 0; k < COMMIT_W; k++) begin
                if (cm_valid[k]) begin
                    r_busy[w_cidx[k]] <= 1'b0;
                    r_done[w_cidx[k]] <= 1'b0;
                    if (w_crel[k]) r_rf_busy[w_crd[k]] <= 1'b0;
                end
            end
            // dispatch comes last so a same-cycle rename of the same rd keeps it busy
            if (w_disp) begin
                r_busy[r_tail] <= 1'b1;
                if (disp_rd != 5'd0) r_rf_busy[w_drd] <= 1'b1;
                r_tail <= r_tail + 1'b1;
            end
            r_head  <= r_head + w_ncm[IW-1:0];
            r_count <= r_count + {{IW{1'b0}}, w_disp} - w_ncm;
        end
    end

    // payload storage; validity is carried by the control state above
    always_ff @(posedge clock) begin
        if (w_disp) begin
            r_rd[r_tail]    <= disp_rd;
            r_pc[r_tail]    <= disp_pc;
            r_pnpc[r_tail]  <= disp_pnpc;
            r_store[r_tail] <= disp_store;
            r_fence[r_tail] <= disp_fence_i;
            if (disp_rd != 5'd0) r_rf_reorder[w_drd] <= r_tail;
        end
        for (int i = NUM_WB - 1; i >= 0; i--) begin
            if (w_wb_hit[i]) begin
                r_value[w_wb_idx[i]] <= wb_result[i*XLEN +: XLEN];
                r_npc[w_wb_idx[i]]   <= wb_npc[i*XLEN +: XLEN];
                r_br[w_wb_idx[i]]    <= wb_br[i];
            end
        end
    end

    // two writeback ports must never target the same tag in one cycle
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_WB; i++)
            for (int j = i + 1; j < NUM_WB; j++)
                if (reset && wb_valid[i] && wb_valid[j])
                    assert (wb_dest[i*TW +: TW] != wb_dest[j*TW +: TW]);
    end

endmodule

// File: tb/tb_ysyx_rob_mc.sv
// tb_ysyx_rob_mc: directed scenarios plus randomized traffic checked against a queue-based ROB model
module tb_ysyx_rob_mc;

    localparam int TW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        disp_valid, disp_ready, disp_store, disp_fence_i;
    logic [4:0]  disp_rd, disp_rs1, disp_rs2;
    logic [31:0] disp_pc, disp_pnpc;
    logic [3:0]  disp_dest, rs1_q, rs2_q;
    logic        rs1_fwd, rs2_fwd;
    logic [31:0] rs1_value, rs2_value;
    logic [1:0]  wb_valid, wb_br;
    logic [7:0]  wb_dest;
    logic [63:0] wb_result, wb_npc;
    logic [1:0]  cm_valid, cm_store;
    logic [9:0]  cm_rd;
    logic [63:0] cm_value, cm_pc, cm_npc;
    logic        flush_pipeline;

    ysyx_rob_mc dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
        .disp_pc(disp_pc), .disp_pnpc(disp_pnpc), .disp_store(disp_store), .disp_fence_i(disp_fence_i),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_dest(disp_dest),
        .rs1_q(rs1_q), .rs1_fwd(rs1_fwd), .rs1_value(rs1_value),
        .rs2_q(rs2_q), .rs2_fwd(rs2_fwd), .rs2_value(rs2_value),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result), .wb_npc(wb_npc), .wb_br(wb_br),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_value(cm_value), .cm_pc(cm_pc), .cm_npc(cm_npc),
        .cm_store(cm_store), .flush_pipeline(flush_pipeline)
    );

    always #20 clock = ~clock;

    typedef struct {
        int          idx;
        logic [4:0]  rd;
        logic [31:0] pc, pnpc, npc, val;
        bit          store, fence, br, done;
    } ent_t;

    ent_t q[$];
    int   mtail;
    bit   mflush;
    int   n_vec;
    int   n_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void mclear();
        q.delete();
        mtail  = 0;
        mflush = 0;
    endfunction

    function automatic int ncommit(output bit stop);
        int n;
        n    = 0;
        stop = 0;
        if (mflush) return 0;
        for (int k = 0; k < 2; k++) begin
            if (k >= q.size()) break;
            if (!q[k].done) break;
            n++;
            if (q[k].fence || (q[k].br && q[k].npc != q[k].pnpc)) begin
                stop = 1;
                break;
            end
        end
        return n;
    endfunction

    // producer = youngest uncommitted entry writing rs
    function automatic void look(input logic [4:0] rs, output logic [3:0] tq, output bit f, output logic [31:0] v);
        tq = 0;
        f  = 0;
        v  = 0;
        if (rs == 0) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rd == rs) begin
                if (q[i].done) begin
                    f = 1;
                    v = q[i].val;
                end else begin
                    tq = 4'(q[i].idx + 1);
                    for (int p = 1; p >= 0; p--) begin
                        if (wb_valid[p] && wb_dest[p*4 +: 4] == 4'(q[i].idx + 1)) begin
                            tq = 0;
                            f  = 1;
                            v  = wb_result[p*32 +: 32];
                        end
                    end
                end
                return;
            end
        end
    endfunction

    function automatic void mupdate();
        bit   stop;
        int   n;
        bit   rdy;
        ent_t e;
        if (mflush) begin
            mclear();
            return;
        end
        rdy = q.size() < 8;
        n   = ncommit(stop);
        repeat (n) void'(q.pop_front());
        for (int p = 0; p < 2; p++) begin
            if (wb_valid[p]) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].idx + 1 == int'(wb_dest[p*4 +: 4]) && !q[i].done) begin
                        q[i].done = 1;
                        q[i].val  = wb_result[p*32 +: 32];
                        q[i].npc  = wb_npc[p*32 +: 32];
                        q[i].br   = wb_br[p];
                        break;
                    end
                end
            end
        end
        if (disp_valid && rdy) begin
            e.idx   = mtail;
            e.rd    = disp_rd;
            e.pc    = disp_pc;
            e.pnpc  = disp_pnpc;
            e.npc   = 0;
            e.val   = 0;
            e.store = disp_store;
            e.fence = disp_fence_i;
            e.br    = 0;
            e.done  = 0;
            q.push_back(e);
            mtail = (mtail + 1) % 8;
        end
        mflush = stop;
    endfunction

    task automatic idle();
        disp_valid   = 0;
        disp_rd      = 0;
        disp_pc      = 0;
        disp_pnpc    = 0;
        disp_store   = 0;
        disp_fence_i = 0;
        disp_rs1     = 0;
        disp_rs2     = 0;
        wb_valid     = 0;
        wb_dest      = 0;
        wb_result    = 0;
        wb_npc       = 0;
        wb_br        = 0;
    endtask

    task automatic disp(input int rd, input int rs1, input int rs2, input bit fence, input bit st,
                        input logic [31:0] pc, input logic [31:0] pnpc);
        disp_valid   = 1;
        disp_rd      = 5'(rd);
        disp_rs1     = 5'(rs1);
        disp_rs2     = 5'(rs2);
        disp_fence_i = fence;
        disp_store   = st;
        disp_pc      = pc;
        disp_pnpc    = pnpc;
    endtask

    task automatic wbset(input int p, input int t, input logic [31:0] res, input logic [31:0] npc, input bit br);
        wb_valid[p]          = 1;
        wb_dest[p*4 +: 4]    = 4'(t);
        wb_result[p*32 +: 32] = res;
        wb_npc[p*32 +: 32]   = npc;
        wb_br[p]             = br;
    endtask

    // compare every DUT output against the model for the current inputs
    task automatic settle();
        int          n;
        bit          st;
        logic [3:0]  eq;
        bit          ef;
        logic [31:0] ev;
        #1;
        n = ncommit(st);
        chk("cm_valid", cm_valid, 64'((1 << n) - 1));
        for (int k = 0; k < n; k++) begin
            chk("cm_rd", cm_rd[k*5 +: 5], q[k].rd);
            chk("cm_value", cm_value[k*32 +: 32], q[k].val);
            chk("cm_pc", cm_pc[k*32 +: 32], q[k].pc);
            chk("cm_npc", cm_npc[k*32 +: 32], q[k].npc);
            chk("cm_store", cm_store[k], q[k].store);
        end
        chk("disp_ready", disp_ready, (q.size() < 8) && !mflush);
        chk("disp_dest", disp_dest, 64'(mtail + 1));
        chk("flush", flush_pipeline, mflush);
        if (!mflush) begin
            look(disp_rs1, eq, ef, ev);
            chk("rs1_q", rs1_q, eq);
            chk("rs1_fwd", rs1_fwd, ef);
            if (ef) chk("rs1_value", rs1_value, ev);
            look(disp_rs2, eq, ef, ev);
            chk("rs2_q", rs2_q, eq);
            chk("rs2_fwd", rs2_fwd, ef);
            if (ef) chk("rs2_value", rs2_value, ev);
        end
    endtask

    task automatic advance();
        @(posedge clock);
        mupdate();
        @(negedge clock);
        idle();
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic do_reset();
        reset = 0;
        mclear();
        #1;
        reset = 1;
        idle();
    endtask

    task automatic rand_inputs();
        int          pend[$];
        int          tag0;
        logic [31:0] pc;
        tag0 = -1;
        idle();
        pc = $urandom & 32'hFFFF_FFFC;
        if ($urandom % 4 != 0)
            disp($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 6),
                 ($urandom % 16) == 0, 1'($urandom % 2), pc, pc + 4);
        else begin
            disp_rs1 = 5'($urandom_range(0, 6));
            disp_rs2 = 5'($urandom_range(0, 6));
        end
        foreach (q[i]) if (!q[i].done) pend.push_back(i);
        for (int p = 0; p < 2; p++) begin
            int          r;
            int          t;
            int          e;
            logic [31:0] npc;
            bit          br;
            r   = $urandom % 10;
            t   = -1;
            npc = 0;
            br  = 0;
            if (r < 7 && pend.size() > 0) begin
                e   = pend[$urandom_range(0, pend.size() - 1)];
                t   = q[e].idx + 1;
                br  = 1'($urandom % 2);
                npc = (br && ($urandom % 6) == 0) ? $urandom : q[e].pnpc;
            end else if (r < 8) begin
                t   = $urandom_range(0, 8);
                br  = 1'($urandom % 2);
                npc = $urandom;
            end
            if (t >= 0 && t != tag0) begin
                wbset(p, t, $urandom, npc, br);
                if (p == 0) tag0 = t;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle();
        mclear();
        repeat (2) @(negedge clock);

        // dual commit of two same-rd producers
        do_reset();
        chk("rst_ready", disp_ready, 1);
        chk("rst_cm", cm_valid, 0);
        chk("rst_dest", disp_dest, 1);
        chk("rst_flush", flush_pipeline, 0);
        disp(3, 0, 0, 0, 0, 32'h10, 32'h14);
        settle(); chk("dual_dest_a", disp_dest, 1); advance();
        disp(3, 3, 0, 0, 1, 32'h14, 32'h18);
        settle(); chk("dual_rs1q", rs1_q, 1); chk("dual_dest_b", disp_dest, 2); advance();
        wbset(0, 1, 32'hA, 32'h14, 0);
        wbset(1, 2, 32'hB, 32'h18, 0);
        settle(); chk("dual_cm_pre", cm_valid, 0); advance();
        settle(); chk("dual_cm", cm_valid, 2'b11); chk("dual_v1", cm_value[63:32], 32'hB);
        chk("dual_store1", cm_store, 2'b10); advance();
        disp(0, 3, 0, 0, 0, 32'h18, 32'h1C);
        settle(); chk("dual_rel_q", rs1_q, 0); chk("dual_rel_fwd", rs1_fwd, 0); advance();

        // out-of-order writeback
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(0, 0, 0, 0, 0, 32'(32'h40 + 4 * i), 32'(32'h44 + 4 * i));
            cyc();
        end
        wbset(0, 3, 32'h33, 32'h4C, 0);
        settle(); chk("ooo_cm0", cm_valid, 0); advance();
        wbset(1, 2, 32'h22, 32'h48, 0);
        settle(); chk("ooo_cm1", cm_valid, 0); advance();
        wbset(0, 1, 32'h11, 32'h44, 0);
        settle(); chk("ooo_cm2", cm_valid, 0); advance();
        settle(); chk("ooo_cm3", cm_valid, 2'b11); chk("ooo_pc0", cm_pc[31:0], 32'h40); advance();
        settle(); chk("ooo_cm4", cm_valid, 2'b01); chk("ooo_v", cm_value[31:0], 32'h33); advance();

        // full and wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            disp(0, 0, 0, 0, 0, 32'(32'h80 + 4 * i), 32'(32'h84 + 4 * i));
            cyc();
        end
        wbset(0, 1, 32'h1, 32'h84, 0);
        wbset(1, 2, 32'h2, 32'h88, 0);
        disp(0, 0, 0, 0, 0, 32'hA0, 32'hA4);
        settle(); chk("full_ready", disp_ready, 0); advance();
        settle(); chk("full_cm", cm_valid, 2'b11); chk("full_ready_cm", disp_ready, 0); advance();
        disp(0, 0, 0, 0, 0, 32'hA0, 32'hA4);
        settle(); chk("wrap_ready", disp_ready, 1); chk("wrap_dest", disp_dest, 1); advance();

        // writeback bypass at dispatch
        do_reset();
        disp(0, 0, 0, 0, 0, 32'h100, 32'h104); cyc();
        disp(5, 0, 0, 0, 0, 32'h104, 32'h108); cyc();
        disp(0, 0, 5, 0, 0, 32'h108, 32'h10C);
        settle(); chk("byp_q_pre", rs2_q, 2); chk("byp_fwd_pre", rs2_fwd, 0); advance();
        wbset(0, 1, 32'h1, 32'h104, 0);
        wbset(1, 2, 32'hDEAD, 32'h108, 0);
        disp(0, 0, 5, 0, 0, 32'h10C, 32'h110);
        settle(); chk("byp_q", rs2_q, 0); chk("byp_fwd", rs2_fwd, 1); chk("byp_val", rs2_value, 32'hDEAD); advance();
        disp(0, 0, 5, 0, 0, 32'h110, 32'h114);
        settle(); chk("byp_rob_fwd", rs2_fwd, 1); chk("byp_rob_val", rs2_value, 32'hDEAD); advance();

        // mispredict flush
        do_reset();
        disp(0, 0, 0, 0, 0, 32'hFC, 32'h100); cyc();
        disp(7, 0, 0, 0, 0, 32'h100, 32'h104); cyc();
        wbset(0, 1, 32'h0, 32'h200, 1);
        wbset(1, 2, 32'h77, 32'h104, 0);
        cyc();
        settle(); chk("mp_cm", cm_valid, 2'b01); chk("mp_npc", cm_npc[31:0], 32'h200);
        chk("mp_flush0", flush_pipeline, 0); advance();
        disp(0, 0, 0, 0, 0, 32'h200, 32'h204);
        settle(); chk("mp_flush1", flush_pipeline, 1); chk("mp_cm_fl", cm_valid, 0);
        chk("mp_ready_fl", disp_ready, 0); advance();
        disp(0, 7, 0, 0, 0, 32'h200, 32'h204);
        settle(); chk("mp_flush2", flush_pipeline, 0); chk("mp_ready", disp_ready, 1);
        chk("mp_dest", disp_dest, 1); chk("mp_rs1q", rs1_q, 0); chk("mp_rs1fwd", rs1_fwd, 0); advance();

        // asynchronous reset while the buffer holds five EX entries
        do_reset();
        for (int i = 0; i < 5; i++) begin
            disp(i + 1, 0, 0, 0, 0, 32'(32'h300 + 4 * i), 32'(32'h304 + 4 * i));
            cyc();
        end
        disp_rs1 = 3;
        #1;
        chk("pre_rst_q", rs1_q, 3);
        reset = 0;
        mclear();
        #1;
        chk("arst_ready", disp_ready, 1);
        chk("arst_cm", cm_valid, 0);
        chk("arst_dest", disp_dest, 1);
        for (int r = 0; r < 8; r++) begin
            disp_rs1 = 5'(r);
            disp_rs2 = 5'(r + 8);
            #1;
            chk("arst_rs1q", rs1_q, 0);
            chk("arst_rs2q", rs2_q, 0);
        end
        reset = 1;
        idle();
        #1;

        // randomized traffic
        do_reset();
        repeat (3000) begin
            rand_inputs();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_rob_mc.md
Name: ysyx_rob_mc

Overview:
- Parametrised multi-port reorder buffer with register-status (rename) table.
- Sits between the micro-op queue dispatch stage and WBU/commit.
- Accepts one dispatch per cycle and NUM_WB out-of-order writebacks per cycle.
- Retires up to COMMIT_W entries per cycle in order, forwards ready operands at dispatch, and raises a pipeline flush on branch mispredict or fence.i.

Parameters:
- ROB_SIZE, 8, entry count; power of two, ≥4.
- COMMIT_W, 2, max commits per cycle; 1..ROB_SIZE/2.
- NUM_WB, 2, writeback ports.
- XLEN, 32, data width.
- REG_NUM, 16, architectural registers; RL=$clog2(REG_NUM).
- TW = $clog2(ROB_SIZE)+1 (derived): tag width; tag = index+1, tag 0 = "no producer".

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low (0 = reset)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available
- disp_rd  in  5  destination reg; 0 = none
- disp_pc, disp_pnpc  in  XLEN  pc / predicted next pc
- disp_store, disp_fence_i  in  1  entry flags
- disp_rs1, disp_rs2  in  5  source regs for lookup
- disp_dest  out  TW  tag allocated to current dispatch
- rsN_q  out  TW  producer tag (N=1,2); 0 if operand available
- rsN_fwd  out  1  rsN_value valid from ROB/bypass
- rsN_value  out  XLEN  forwarded value
- wb_valid  in  NUM_WB  writeback strobes
- wb_dest  in  NUM_WB*TW  tags
- wb_result, wb_npc  in  NUM_WB*XLEN  result / resolved next pc
- wb_br  in  NUM_WB  entry is a control transfer
- cm_valid  out  COMMIT_W  commit slot valid; contiguous from bit 0
- cm_rd  out  COMMIT_W*5
- cm_value, cm_pc, cm_npc  out  COMMIT_W*XLEN
- cm_store  out  COMMIT_W  store commit; to store queue
- flush_pipeline  out  1  registered one-cycle flush pulse

Behaviour:
- Reset (reset=0, async): head=tail=0, count=0, all busy/done=0, rf_busy=0, flush_pipeline=0. cm_valid=0, disp_ready=1 after release.
- Entry states: FREE -> EX (dispatch) -> WB (writeback) -> FREE (commit).
- disp_ready = (count<ROB_SIZE) && !flush_pipeline; not dependent on same-cycle commits. Dispatch fires on disp_valid&&disp_ready. disp_dest = tail+1. tail wraps modulo ROB_SIZE.
- Dispatch with disp_rd≠0 sets rf_reorder[rd]=tail and rf_busy[rd]=1. rd=0 never busy.
- Operand lookup (combinational), rs=0 or !rf_busy[rs]: q=0, fwd=0.
  - Producer in WB: q=0, fwd=1, value = ROB value.
  - Producer being written this cycle on some wb port (lowest port wins): q=0, fwd=1, value=wb_result.
  - Otherwise q = producer tag, fwd=0.
- Writeback: for each valid port with a tag whose entry is EX: state<=WB, store result, npc, br. Tags of FREE entries are ignored. Two ports hitting one tag in one cycle is illegal (assertion); the lowest port wins.
- Commit: slot k valid iff entries head..head+k are all WB, none of head..head+k-1 is a stop entry, and !flush_pipeline.
  - Stop entry = fence_i, or br with npc≠pnpc. A stop entry commits, and no younger entry commits that cycle.
  - head += number of valid slots; count += dispatched - committed.
- Rename release: per committed entry with rd≠0, clear rf_busy[rd] only if rf_reorder[rd]==its index.
  - Not cleared if the same-cycle dispatch targets that rd.
  - Not cleared if a younger committed slot in the same cycle has the same rd; the youngest slot decides.
- Flush: committing a stop entry sets flush_pipeline=1 at the next edge. During that cycle: dispatch, writeback, commit suppressed. At the following edge the ROB and rf_busy are cleared and flush_pipeline=0.
- Commit outputs are combinational from ROB state; consumer (WBU) must accept them unconditionally.

Test Plan:
- Reset mid-operation: fill 5 entries, assert reset=0 asynchronously -> disp_ready=1, cm_valid=0, count=0 with no clock edge; rs1_q=0 for all regs.
- Dual commit: dispatch A(rd=3), B(rd=3). wb both on ports 0/1 same cycle -> next cycle cm_valid=2'b11, rf_busy[3]=0 after commit; then dispatch rs1=3 -> rs1_q=0, fwd=0.
- Out-of-order wb: dispatch tags 1..4, wb tag 3 then 2 -> no commit until tag 1 written; then cm_valid=2'b11 (tags 1,2), next cycle cm_valid=2'b01 (tag 3).
- Full/wrap: dispatch 8 entries -> disp_ready=0. Commit 2 -> disp_ready=1, next disp_dest=1 (wrapped index 0).
- Bypass: entry tag 2 rd=5 in EX, wb tag 2 result 0xDEAD in the same cycle a dispatch looks up rs2=5 -> rs2_q=0, rs2_fwd=1, rs2_value=0xDEAD.
- Mispredict: entry br pnpc=0x100, wb npc=0x200, younger entry done -> only it commits (cm_valid=2'b01), flush_pipeline=1 one cycle, then count=0, rf_busy=0.
